// File: rtl/joypad_port_ctrl.sv
// joypad_port_ctrl
// Two-pad serial joypad sequencer for the $4016/$4017 CPU ports. Watches the
// CPU read/write strobe levels, runs the strobe/serial-shift protocol, and
// keeps a shadow copy of the keycodes offered by the NIOS II PIO.
module joypad_port_ctrl #(
  parameter int   BIT_COUNT = 8,
  parameter logic FILL_BIT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_sel,
  input  logic        cpu_rden,
  input  logic        cpu_wren,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  open_bus_in,
  output logic [7:0]  cpu_data_out,
  input  logic [15:0] kc_data,
  input  logic        kc_valid,
  output logic        kc_ready,
  output logic        strobe_o
);

  localparam int             CW      = $clog2(BIT_COUNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BIT_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_SHIFT  = 2'd2
  } state_t;

  // Saturating read counter: stops at BIT_COUNT so it never wraps
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // One serial step: LSB leaves, fill bit enters at the MSB
  function automatic logic [7:0] shift_in(input logic [7:0] v);
    shift_in = {FILL_BIT, v[7:1]};
  endfunction

  state_t         state_r, state_nxt_s;
  logic           rden_q_r, wren_q_r;
  logic           rd_rise_s, wr_rise_s, wr_act_s;
  logic           strobe_r;
  logic [15:0]    shadow_r;
  logic [7:0]     shift1_r, shift2_r;
  logic [CW-1:0]  cnt1_r, cnt2_r;
  logic           serial_bit_r, serial_nxt_s;
  logic           kc_ready_r;
  logic           load_s, rd_shift_ok_s;
  logic           shift1_en_s, shift2_en_s;
  logic [7:0]     pad_shift_s, pad_shadow_s;
  logic [CW-1:0]  pad_cnt_s;
  logic           unused_s;

  // Only data bit 0 and the top three open-bus bits carry meaning here
  assign unused_s = ^{cpu_data_in[7:1], open_bus_in[4:0]};

  // Strobe edge detection; a level held for many cycles acts once
  assign rd_rise_s = cpu_rden & ~rden_q_r;
  assign wr_rise_s = cpu_wren & ~wren_q_r;
  // Writes to $4017 belong to the APU frame counter and are ignored
  assign wr_act_s  = wr_rise_s & ~cpu_sel;

  // Register the previous strobe levels for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rden_q_r <= 1'b0;
      wren_q_r <= 1'b0;
    end else begin
      rden_q_r <= cpu_rden;
      wren_q_r <= cpu_wren;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: strobe 1 enters STROBE, strobe 0 from STROBE enters SHIFT
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_SHIFT: begin
        if (wr_act_s && cpu_data_in[0]) begin
          state_nxt_s = ST_STROBE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_STROBE: begin
        if (wr_act_s && !cpu_data_in[0]) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_STROBE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: STROBE reloads every cycle, other states let reads shift
  always_comb begin
    load_s        = 1'b0;
    rd_shift_ok_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s        = 1'b0;
        rd_shift_ok_s = 1'b1;
      end
      ST_STROBE: begin
        load_s        = 1'b1;
        rd_shift_ok_s = 1'b0;
      end
      ST_SHIFT: begin
        load_s        = 1'b0;
        rd_shift_ok_s = 1'b1;
      end
      default: begin
        load_s        = 1'b0;
        rd_shift_ok_s = 1'b0;
      end
    endcase
  end

  // A colliding write wins: the read still samples but does not shift
  assign shift1_en_s = rd_rise_s & ~wr_act_s & rd_shift_ok_s & ~cpu_sel;
  assign shift2_en_s = rd_rise_s & ~wr_act_s & rd_shift_ok_s &  cpu_sel;

  assign pad_shift_s  = cpu_sel ? shift2_r       : shift1_r;
  assign pad_shadow_s = cpu_sel ? shadow_r[15:8] : shadow_r[7:0];
  assign pad_cnt_s    = cpu_sel ? cnt2_r         : cnt1_r;

  // Select the bit returned by a read on the addressed pad
  always_comb begin
    serial_nxt_s = serial_bit_r;
    if (rd_rise_s) begin
      if (wr_act_s) begin
        serial_nxt_s = pad_shift_s[0];
      end else if (load_s) begin
        serial_nxt_s = pad_shadow_s[0];
      end else if (pad_cnt_s == CNT_MAX) begin
        serial_nxt_s = FILL_BIT;
      end else begin
        serial_nxt_s = pad_shift_s[0];
      end
    end else begin
      serial_nxt_s = serial_bit_r;
    end
  end

  // Registered serial bit, held until the next read edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      serial_bit_r <= 1'b0;
    end else begin
      serial_bit_r <= serial_nxt_s;
    end
  end

  // Strobe register written from $4016 bit 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_r <= 1'b0;
    end else if (wr_act_s) begin
      strobe_r <= cpu_data_in[0];
    end else begin
      strobe_r <= strobe_r;
    end
  end

  // Pad 1 shift register and read counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift1_r <= 8'h00;
      cnt1_r   <= {CW{1'b0}};
    end else if (load_s) begin
      shift1_r <= shadow_r[7:0];
      cnt1_r   <= {CW{1'b0}};
    end else if (shift1_en_s) begin
      shift1_r <= shift_in(shift1_r);
      cnt1_r   <= sat_inc(cnt1_r);
    end else begin
      shift1_r <= shift1_r;
      cnt1_r   <= cnt1_r;
    end
  end

  // Pad 2 shift register and read counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift2_r <= 8'h00;
      cnt2_r   <= {CW{1'b0}};
    end else if (load_s) begin
      shift2_r <= shadow_r[15:8];
      cnt2_r   <= {CW{1'b0}};
    end else if (shift2_en_s) begin
      shift2_r <= shift_in(shift2_r);
      cnt2_r   <= sat_inc(cnt2_r);
    end else begin
      shift2_r <= shift2_r;
      cnt2_r   <= cnt2_r;
    end
  end

  // Keycode handshake: ready once out of reset, shadow captured on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_ready_r <= 1'b0;
      shadow_r   <= 16'h0000;
    end else begin
      kc_ready_r <= 1'b1;
      if (kc_valid && kc_ready_r) begin
        shadow_r <= kc_data;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  assign kc_ready     = kc_ready_r;
  assign strobe_o     = strobe_r;
  assign cpu_data_out = {open_bus_in[7:5], 4'b0000, serial_bit_r};

endmodule

// File: tb/tb_joypad_port_ctrl.sv
// Self-checking bench for joypad_port_ctrl: directed protocol scenarios
// followed by random bus/keycode traffic, compared against a per-pad model
// that tracks the latched byte and how many bits have been read.
module tb_joypad_port_ctrl;

  localparam logic FILL = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_sel = 1'b0;
  logic        cpu_rden = 1'b0;
  logic        cpu_wren = 1'b0;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  open_bus_in = 8'h00;
  logic [7:0]  cpu_data_out;
  logic [15:0] kc_data = 16'h0000;
  logic        kc_valid = 1'b0;
  logic        kc_ready;
  logic        strobe_o;

  int vec = 0;
  int errs = 0;

  // Reference model state
  logic [15:0] m_shadow;
  logic [7:0]  m_lat [2];
  int          m_idx [2];
  logic        m_strobe;

  joypad_port_ctrl #(.BIT_COUNT(8), .FILL_BIT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_sel(cpu_sel), .cpu_rden(cpu_rden),
    .cpu_wren(cpu_wren), .cpu_data_in(cpu_data_in), .open_bus_in(open_bus_in),
    .cpu_data_out(cpu_data_out), .kc_data(kc_data), .kc_valid(kc_valid),
    .kc_ready(kc_ready), .strobe_o(strobe_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit the next read of pad n should return
  function automatic logic model_bit(input int n);
    if (m_strobe) return m_shadow[8*n];
    else if (m_idx[n] >= 8) return FILL;
    else return m_lat[n][m_idx[n]];
  endfunction

  // Expected shift-register contents after m_idx reads in SHIFT/IDLE
  function automatic logic [7:0] model_shift(input int n);
    logic [7:0] ones;
    ones = 8'hFF;
    if (m_idx[n] >= 8) return 8'hFF;
    else return (m_lat[n] >> m_idx[n]) | ~(ones >> m_idx[n]);
  endfunction

  task automatic model_reset();
    m_shadow = 16'h0000;
    m_lat[0] = 8'h00; m_lat[1] = 8'h00;
    m_idx[0] = 0;     m_idx[1] = 0;
    m_strobe = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    check("kc_ready_before_push", {15'd0, kc_ready}, 16'd1);
    kc_data = d;
    kc_valid = 1'b1;
    tick();
    kc_valid = 1'b0;
    kc_data = 16'($urandom);
    m_shadow = d;
  endtask

  task automatic wr(input logic sel, input logic d);
    cpu_sel = sel;
    cpu_data_in = 8'($urandom);
    cpu_data_in[0] = d;
    cpu_wren = 1'b1;
    tick();
    cpu_wren = 1'b0;
    tick();
    if (!sel) begin
      if (m_strobe && !d) begin
        m_lat[0] = m_shadow[7:0];
        m_lat[1] = m_shadow[15:8];
        m_idx[0] = 0;
        m_idx[1] = 0;
      end
      m_strobe = d;
    end
    check("strobe_after_write", {15'd0, strobe_o}, {15'd0, m_strobe});
  endtask

  task automatic rd(input logic sel, input int hold);
    logic exp;
    int n;
    n = sel ? 1 : 0;
    exp = model_bit(n);
    open_bus_in = 8'($urandom);
    cpu_sel = sel;
    cpu_rden = 1'b1;
    tick();
    check(sel ? "read_4017" : "read_4016", {8'h00, cpu_data_out},
          {8'h00, open_bus_in[7:5], 4'b0000, exp});
    repeat (hold - 1) tick();
    cpu_rden = 1'b0;
    tick();
    check("read_hold", {15'd0, cpu_data_out[0]}, {15'd0, exp});
    if (!m_strobe && m_idx[n] < 8) m_idx[n]++;
  endtask

  initial begin
    logic [15:0] r;
    logic        exp_bit;
    model_reset();

    // Reset state while held in reset
    open_bus_in = 8'hE3;
    #2;
    check("reset_data_out", {8'h00, cpu_data_out}, 16'h00E0);
    check("reset_kc_ready", {15'd0, kc_ready}, 16'd0);
    check("reset_strobe", {15'd0, strobe_o}, 16'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("kc_ready_after_release", {15'd0, kc_ready}, 16'd1);

    // Reads in IDLE return zeros then fill bits
    for (int i = 0; i < 10; i++) rd(1'b0, 1);

    // Full read of 8'hA5 from $4016
    push(16'h00A5);
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    check("pad2_latched", {8'h00, dut.shift2_r}, {8'h00, model_shift(1)});
    for (int i = 0; i < 10; i++) rd(1'b0, 1);
    check("pad2_untouched", {8'h00, dut.shift2_r}, {8'h00, model_shift(1)});
    check("pad2_untouched_abs", {8'h00, dut.shift2_r}, 16'h0000);

    // Reset mid-SHIFT after reading a 1
    push(16'h00FF);
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    rd(1'b0, 1);
    rd(1'b0, 1);
    reset_n = 1'b0;
    #1;
    check("midreset_bit", {15'd0, cpu_data_out[0]}, 16'd0);
    check("midreset_kc_ready", {15'd0, kc_ready}, 16'd0);
    check("midreset_strobe", {15'd0, strobe_o}, 16'd0);
    tick();
    reset_n = 1'b1;
    model_reset();
    check("kc_ready_release_low", {15'd0, kc_ready}, 16'd0);
    tick();
    check("kc_ready_release_high", {15'd0, kc_ready}, 16'd1);
    rd(1'b0, 1);

    // Strobe held: A returned repeatedly, tracks shadow updates
    r = 16'($urandom);
    push({r[15:8], 8'h01});
    wr(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) rd(1'b0, 1);
    push(16'h0000);
    rd(1'b0, 1);
    wr(1'b0, 1'b0);

    // Multi-cycle read strobes count once each
    push(16'($urandom));
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) rd(1'b0, 5);
    check("cnt1_saturated", 16'(dut.cnt1_r), 16'd8);
    rd(1'b0, 3);
    check("cnt1_no_wrap", 16'(dut.cnt1_r), 16'd8);

    // Keycode update during SHIFT does not tear the latched byte
    push(16'hFF00);
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rd(1'b1, 1);
    push(16'h0000);
    for (int i = 0; i < 5; i++) rd(1'b1, 1);

    // Collision: write 1 and read on the same edge
    push(16'($urandom));
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    rd(1'b0, 1);
    exp_bit = model_bit(0);
    cpu_sel = 1'b0;
    cpu_data_in = 8'h01;
    cpu_wren = 1'b1;
    cpu_rden = 1'b1;
    tick();
    m_strobe = 1'b1;
    check("collision_strobe", {15'd0, strobe_o}, 16'd1);
    check("collision_bit", {15'd0, cpu_data_out[0]}, {15'd0, exp_bit});
    check("collision_no_shift", {8'h00, dut.shift1_r}, {8'h00, model_shift(0)});
    cpu_wren = 1'b0;
    cpu_rden = 1'b0;
    tick();
    check("collision_reload", {8'h00, dut.shift1_r}, {8'h00, m_shadow[7:0]});
    wr(1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       push(16'($urandom));
        1:       wr(1'($urandom), 1'($urandom));
        default: rd(1'($urandom), int'($urandom_range(1, 4)));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
